// File: rtl/tt_onehot_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tt_onehot_rr_arbiter
//
// Round-robin arbiter whose grant vector drives a decoded (one-hot select) mux.
// A requester wins from the round-robin pointer upward, with wrap-around. It
// then keeps the grant for a whole burst. The burst ends when an accepted beat
// is marked last, or when MAX_BURST beats have been accepted; the second case
// is a forced release and pulses o_burst_overflow. Exactly one idle cycle
// separates consecutive grants. o_grant is therefore always one-hot or zero.
//
// Ports
//   i_clk            clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_req            per-requester "beat available" levels
//   i_last           current beat of the granted requester is the last one
//   i_ready          downstream accepts the presented beat this cycle
//   o_grant          registered one-hot grant (mux select), zero when idle
//   o_grant_idx      binary index of o_grant, zero when no grant
//   o_valid          granted requester presents a beat
//   o_accept         beat transferred this cycle (o_valid & i_ready)
//   o_burst_overflow single-cycle pulse on the accept that forces a release
// ----------------------------------------------------------------------------

`ifndef ASSERT_COND_CLK
`define ASSERT_COND_CLK(cond_en, clk, prop, msg) \
    assert property (@(posedge clk) (cond_en) |-> (prop)) else $error(msg);
`endif

// ----------------------------------------------------------------------------
// tt_onehot_rr_arbiter_chk
//
// Simulation-only invariants for the arbiter outputs.
// Ports: i_clk, i_reset, o_grant, o_accept, o_burst_overflow (all observed).
// ----------------------------------------------------------------------------
module tt_onehot_rr_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               i_clk,
    input logic               i_reset,
    input logic [NUM_REQ-1:0] o_grant,
    input logic               o_accept,
    input logic               o_burst_overflow
);

    // The grant is a mux select: never more than one bit set.
    `ASSERT_COND_CLK(!i_reset, i_clk, $onehot0(o_grant), "o_grant is not one-hot or zero")

    // A forced release can only happen on a transferred beat.
    `ASSERT_COND_CLK(!i_reset, i_clk, (!o_burst_overflow || o_accept), "overflow without accept")

endmodule

module tt_onehot_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic                 i_last,
    input  logic                 i_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [IDX_WIDTH-1:0] o_grant_idx,
    output logic                 o_valid,
    output logic                 o_accept,
    output logic                 o_burst_overflow
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0]     MAX_CNT     = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]     CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_REQ - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE     = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0]   ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [IDX_WIDTH-1:0] grant_idx_r;
    logic [IDX_WIDTH-1:0] rr_ptr_r;
    logic [CNT_W-1:0]     count_r;

    logic                 win_found_s;
    logic [IDX_WIDTH-1:0] win_idx_s;
    logic [IDX_WIDTH-1:0] cand_s;
    logic                 valid_s;
    logic                 accept_s;
    logic [CNT_W-1:0]     count_inc_s;
    logic                 count_hits_max_s;
    logic                 release_s;
    logic                 overflow_s;
    logic [IDX_WIDTH-1:0] next_ptr_s;

    // Round-robin search: walk the candidates starting at the pointer and
    // wrapping by explicit compare, so non-power-of-2 NUM_REQ never indexes
    // past the last requester.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDX_WIDTH{1'b0}};
        cand_s      = rr_ptr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found_s && i_req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
            if (cand_s == LAST_IDX) begin
                cand_s = {IDX_WIDTH{1'b0}};
            end else begin
                cand_s = cand_s + IDX_ONE;
            end
        end
    end

    // Beat handshake and burst-termination decode for the current cycle.
    always_comb begin
        valid_s  = |(grant_r & i_req);
        accept_s = valid_s & i_ready;

        // Saturate so the counter can never wrap even if a release were missed.
        if (count_r == MAX_CNT) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + CNT_ONE;
        end

        count_hits_max_s = (count_inc_s == MAX_CNT);

        // A last beat releases normally; the beat limit only counts as an
        // overflow when the beat was not already marked last.
        release_s  = accept_s & (i_last | count_hits_max_s);
        overflow_s = accept_s & ~i_last & count_hits_max_s;

        if (grant_idx_r == LAST_IDX) begin
            next_ptr_s = {IDX_WIDTH{1'b0}};
        end else begin
            next_ptr_s = grant_idx_r + IDX_ONE;
        end
    end

    // Arbiter state machine: grant on the edge after a request is seen in
    // IDLE, hold through the burst, return to IDLE for one bubble on release.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            grant_r     <= {NUM_REQ{1'b0}};
            grant_idx_r <= {IDX_WIDTH{1'b0}};
            rr_ptr_r    <= {IDX_WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        state_r     <= ST_BUSY;
                        grant_r     <= ONE_HOT_LSB << win_idx_s;
                        grant_idx_r <= win_idx_s;
                        count_r     <= {CNT_W{1'b0}};
                    end else begin
                        state_r     <= ST_IDLE;
                        grant_r     <= {NUM_REQ{1'b0}};
                        grant_idx_r <= {IDX_WIDTH{1'b0}};
                    end
                end
                ST_BUSY: begin
                    // Burst lock: other requesters are ignored until release,
                    // even while the granted requester has nothing to send.
                    if (release_s) begin
                        state_r     <= ST_IDLE;
                        grant_r     <= {NUM_REQ{1'b0}};
                        grant_idx_r <= {IDX_WIDTH{1'b0}};
                        rr_ptr_r    <= next_ptr_s;
                        count_r     <= {CNT_W{1'b0}};
                    end else if (accept_s) begin
                        count_r     <= count_inc_s;
                    end else begin
                        count_r     <= count_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant_r     <= {NUM_REQ{1'b0}};
                    grant_idx_r <= {IDX_WIDTH{1'b0}};
                    count_r     <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign o_grant          = grant_r;
    assign o_grant_idx      = grant_idx_r;
    assign o_valid          = valid_s;
    assign o_accept         = accept_s;
    assign o_burst_overflow = overflow_s;

`ifndef SYNTHESIS
    tt_onehot_rr_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .o_grant          (grant_r),
        .o_accept         (accept_s),
        .o_burst_overflow (overflow_s)
    );
`endif

endmodule

// File: tb/tb_tt_onehot_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tt_onehot_rr_arbiter
//
// Directed testbench for tt_onehot_rr_arbiter (NUM_REQ=4, MAX_BURST=16).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later,
// well away from the next edge. Expected values are worked out by hand from
// the arbitration rules and written into the stimulus below.
// ----------------------------------------------------------------------------
module tb_tt_onehot_rr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 16;
    localparam int IDX_WIDTH = 2;

    logic                 i_clk;
    logic                 i_reset;
    logic [NUM_REQ-1:0]   i_req;
    logic                 i_last;
    logic                 i_ready;
    logic [NUM_REQ-1:0]   o_grant;
    logic [IDX_WIDTH-1:0] o_grant_idx;
    logic                 o_valid;
    logic                 o_accept;
    logic                 o_burst_overflow;

    int num_checks;
    int num_errors;

    tt_onehot_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST),
        .IDX_WIDTH (IDX_WIDTH)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_req            (i_req),
        .i_last           (i_last),
        .i_ready          (i_ready),
        .o_grant          (o_grant),
        .o_grant_idx      (o_grant_idx),
        .o_valid          (o_valid),
        .o_accept         (o_accept),
        .o_burst_overflow (o_burst_overflow)
    );

    // 100 MHz clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 1 ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Apply inputs, let combinational outputs settle, then check all outputs.
    task automatic drive_check(input string tag, input logic [3:0] req, input logic last,
                               input logic ready, input logic [3:0] exp_grant,
                               input logic [1:0] exp_idx, input logic exp_valid,
                               input logic exp_accept, input logic exp_ovf);
        i_req   = req;
        i_last  = last;
        i_ready = ready;
        #1;
        check_value({tag, "_grant"},  32'(o_grant),          32'(exp_grant));
        check_value({tag, "_idx"},    32'(o_grant_idx),      32'(exp_idx));
        check_value({tag, "_valid"},  32'(o_valid),          32'(exp_valid));
        check_value({tag, "_accept"}, 32'(o_accept),         32'(exp_accept));
        check_value({tag, "_ovf"},    32'(o_burst_overflow), 32'(exp_ovf));
    endtask

    initial begin
        logic [3:0] rot_grant [5];
        logic [1:0] rot_idx   [5];
        logic       rdy;
        logic       lst;
        int         acc;

        num_checks = 0;
        num_errors = 0;
        i_reset = 1'b1;
        i_req   = 4'b0000;
        i_last  = 1'b0;
        i_ready = 1'b0;

        // ---- Reset state -------------------------------------------------
        step();
        step();
        drive_check("rst", 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;

        // ---- 1: req=1010, every beat last, pointer 0 -> req1 then req3 ---
        drive_check("t1_idle", 4'b1010, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_check("t1_g1", 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        drive_check("t1_bub", 4'b1010, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_check("t1_g3", 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
        step();
        // Pointer is now 0 again.

        // ---- 2: all requesting, every beat last -> full rotation ---------
        rot_grant[0] = 4'b0001; rot_idx[0] = 2'd0;
        rot_grant[1] = 4'b0010; rot_idx[1] = 2'd1;
        rot_grant[2] = 4'b0100; rot_idx[2] = 2'd2;
        rot_grant[3] = 4'b1000; rot_idx[3] = 2'd3;
        rot_grant[4] = 4'b0001; rot_idx[4] = 2'd0;
        drive_check("t2_idle", 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            drive_check($sformatf("t2_g%0d", k), 4'b1111, 1'b1, 1'b1,
                        rot_grant[k], rot_idx[k], 1'b1, 1'b1, 1'b0);
            step();
            drive_check($sformatf("t2_bub%0d", k), 4'b1111, 1'b1, 1'b1,
                        4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        // The bubble cycle above already granted again from pointer 1; let
        // that grant finish with a last beat and settle to idle with only
        // req0 requesting. After req1's burst the pointer is 2.
        step();
        drive_check("t2_tail", 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        step();

        // ---- 3: req0 five-beat burst, ready toggling, last on 5th accept -
        drive_check("t3_idle", 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        acc = 0;
        for (int k = 0; k < 9; k++) begin
            rdy = (k % 2 == 0);
            lst = (acc == 4);
            drive_check($sformatf("t3_b%0d", k), 4'b0001, lst, rdy,
                        4'b0001, 2'd0, 1'b1, rdy, 1'b0);
            if (rdy) acc++;
            step();
        end
        // Pointer is now 1.
        drive_check("t3_rel", 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // ---- 4: req2 never last, forced release on 16th accept -----------
        drive_check("t4_idle", 4'b1100, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < MAX_BURST; k++) begin
            drive_check($sformatf("t4_b%0d", k), 4'b1100, 1'b0, 1'b1,
                        4'b0100, 2'd2, 1'b1, 1'b1, (k == MAX_BURST - 1));
            step();
        end
        drive_check("t4_rel", 4'b1100, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_check("t4_next", 4'b1100, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
        step();
        // Pointer is now 0.

        // ---- 5: req1 drops mid-burst, req0/req3 must not be regranted -----
        drive_check("t5_idle", 4'b0010, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_check("t5_b0", 4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            // i_last without an accept must not end the burst.
            drive_check($sformatf("t5_drop%0d", k), 4'b1001, 1'b1, 1'b1,
                        4'b0010, 2'd1, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive_check("t5_back", 4'b1011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        drive_check("t5_rel", 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // Pointer is now 2.

        // ---- 6: asynchronous reset mid-burst with grant 0100 --------------
        drive_check("t6_idle", 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_check("t6_busy", 4'b1101, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        i_reset = 1'b1;
        drive_check("t6_async", 4'b1101, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        i_reset = 1'b0;
        drive_check("t6_post", 4'b1101, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        // Pointer was cleared by reset, so req0 wins over req2/req3.
        drive_check("t6_win", 4'b1101, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive_check("t6_end", 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
